// File: rtl/alu_seq_exec.sv
// alu_seq_exec -- execute-stage ALU fed by ALU_Ctrl.
//   Single-cycle ops (and/or/add/sub/slt) register their result one clock
//   after start.  mul runs an iterative shift-add multiplier for WIDTH clocks,
//   with busy_o high while it iterates.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-low reset
//   start_i   launch an operation (sampled only in IDLE)
//   ctrl_i    ALUCtrl code: 0000 and, 0001 or, 0010 add, 0110 sub,
//             0111 slt, 1000 mul, others nop (result 0)
//   src1_i    operand A, captured at start
//   src2_i    operand B, captured at start
//   result_o  registered result, held until the next completion
//   zero_o    registered (result_o == 0)
//   busy_o    high while mul iterates
//   valid_o   one-cycle pulse when result_o/zero_o have just updated
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;

  // Combinational single-cycle datapath on the live operands.
  always_comb begin
    alu_res = '0;
    unique case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default: alu_res = '0;
    endcase
  end

  // Accumulator value after this multiplier step.
  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_o;
    zero_d   = zero_o;
    valid_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (ctrl_i == OP_MUL) begin
            a_d     = src1_i;
            b_d     = src2_i;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - 1'b1;
        // Last iteration: publish the sum including this step's partial product.
        if (cnt_q == CW'(1)) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
      valid_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_o <= result_d;
      zero_o   <= zero_d;
      valid_o  <= valid_d;
    end
  end

  assign busy_o = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec -- self-checking bench for alu_seq_exec (WIDTH=32):
// directed vector table, hand-written multi-cycle sequences, and randomized
// operations checked against a plain-arithmetic reference.
module tb_alu_seq_exec;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   ctrl_i = 4'h0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         busy_o;
  logic         valid_o;

  int total = 0;
  int bad   = 0;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the arithmetic meaning of each ALUCtrl code.
  function automatic logic [W-1:0] ref_op(input logic [3:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint signed    sa, sb;
    longint unsigned  prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return W'((longint'(a) + longint'(b)) % (64'd1 << W));
      4'b0110: return W'((longint'(a) - longint'(b) + (64'd1 << W)) % (64'd1 << W));
      4'b0111: return (sa < sb) ? W'(1) : W'(0);
      4'b1000: begin
        prod = longint'(a) * longint'(b);
        return W'(prod % (64'd1 << W));
      end
      default: return '0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Launch one operation, wait (bounded) for its valid pulse, check everything.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    logic [W-1:0] exp;
    int lat, busy_cnt;
    exp = ref_op(c, a, b);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    tick();
    start_i = 1'b0;
    ctrl_i  = 4'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
    lat = 1; busy_cnt = 0;
    while (!valid_o && lat <= W + 5) begin
      if (busy_o) busy_cnt++;
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), (c == 4'b1000) ? 64'(W + 1) : 64'd1);
    check({name, " busy cycles"}, 64'(busy_cnt), (c == 4'b1000) ? 64'(W) : 64'd0);
    check({name, " busy at valid"}, 64'(busy_o), 64'd0);
    check({name, " result"}, 64'(result_o), 64'(exp));
    check({name, " zero"}, 64'(zero_o), 64'(exp == '0));
    tick();
    check({name, " valid drop"}, 64'(valid_o), 64'd0);
  endtask

  initial begin
    vec_t vecs[10];
    logic [3:0] ops[8];
    logic [W-1:0] held;
    int cyc, pulses;

    vecs[0] = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{4'b0110, 32'd3,          32'd3,          32'd0,          1'b1};
    vecs[2] = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[3] = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[4] = '{4'b0000, 32'hF0,         32'h3C,         32'h30,         1'b0};
    vecs[5] = '{4'b0001, 32'hF0,         32'h3C,         32'hFC,         1'b0};
    vecs[6] = '{4'b1111, 32'h1234,       32'h5678,       32'd0,          1'b1};
    vecs[7] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[8] = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[9] = '{4'b0111, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0};

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1111, 4'b0011};

    // Reset state
    tick(); tick();
    check("reset result", 64'(result_o), 64'd0);
    check("reset zero",   64'(zero_o),   64'd1);
    check("reset busy",   64'(busy_o),   64'd0);
    check("reset valid",  64'(valid_o),  64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Vector table, applied back-to-back (start held high).
    for (int i = 0; i < 10; i++) begin
      start_i = 1'b1; ctrl_i = vecs[i].ctrl; src1_i = vecs[i].a; src2_i = vecs[i].b;
      tick();
      check($sformatf("vec%0d valid", i),  64'(valid_o),  64'd1);
      check($sformatf("vec%0d busy", i),   64'(busy_o),   64'd0);
      check($sformatf("vec%0d result", i), 64'(result_o), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d zero", i),   64'(zero_o),   64'(vecs[i].exp_zero));
    end
    start_i = 1'b0;
    held = result_o;
    tick(); tick();
    check("idle valid", 64'(valid_o), 64'd0);
    check("idle hold",  64'(result_o), 64'(held));

    // mul 0xFFFFFFFF*3 with an ignored start at T+5.
    start_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'hFFFF_FFFF; src2_i = 32'd3;
    tick();
    start_i = 1'b0;
    check("mul busy T+1", 64'(busy_o), 64'd1);
    tick(); tick(); tick();
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
    tick();
    start_i = 1'b0;
    cyc = 5;
    while (!valid_o && cyc < W + 10) begin
      tick();
      cyc++;
    end
    check("mul ignore latency", 64'(cyc), 64'(W + 1));
    check("mul ignore result", 64'(result_o), 64'hFFFF_FFFD);
    check("mul ignore zero", 64'(zero_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    check("mul no second result", 64'(pulses), 64'd0);

    // Reset during MUL cycle 10.
    start_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'h12345; src2_i = 32'h777;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre-reset busy", 64'(busy_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check("async reset busy",   64'(busy_o),   64'd0);
    check("async reset result", 64'(result_o), 64'd0);
    check("async reset zero",   64'(zero_o),   64'd1);
    check("async reset valid",  64'(valid_o),  64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o || busy_o) pulses++;
    end
    check("post-reset quiet", 64'(pulses), 64'd0);
    run_op(4'b0010, 32'd2, 32'd2, "post-reset add");

    // Back-to-back: mul 6*7 then add 1+1 in the valid cycle.
    start_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'd6; src2_i = 32'd7;
    tick();
    start_i = 1'b0;
    cyc = 1;
    while (!valid_o && cyc < W + 10) begin
      tick();
      cyc++;
    end
    check("b2b mul latency", 64'(cyc), 64'(W + 1));
    check("b2b mul result", 64'(result_o), 64'd42);
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
    tick();
    start_i = 1'b0;
    check("b2b add valid",  64'(valid_o),  64'd1);
    check("b2b add result", 64'(result_o), 64'd2);
    tick();
    check("b2b valid drop", 64'(valid_o), 64'd0);

    // Randomized operations against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      logic [W-1:0] a, b;
      c = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      if (i % 7 == 0) b = W'($urandom_range(0, 15));
      run_op(c, a, b, $sformatf("rand%0d op%0h", i, c));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
